// File: rtl/stall_pkg.sv
// Shared definitions for the latency-scoreboard stall unit: default widths,
// stall-cause encodings and per-unit result latencies.
package stall_pkg;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int LAT_W_DEF      = 3;

   typedef enum logic [1:0] {
      STALL_NONE = 2'b00,
      STALL_RS1  = 2'b01,
      STALL_RS2  = 2'b10,
      STALL_BOTH = 2'b11
   } stall_type_e;

   // Extra cycles after issue before the result can be forwarded
   localparam int LAT_ALU  = 0;
   localparam int LAT_LOAD = 1;
   localparam int LAT_MUL  = 3;

endpackage

// File: rtl/reg_lat_counter.sv
// One register's countdown: cycles remaining until its pending result is
// forwardable. Saturates at zero; a new writer loads the larger of the two.
module reg_lat_counter #(
   parameter int LAT_W = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [LAT_W-1:0] i_lat,
   output logic [LAT_W-1:0] o_cnt
);

   logic [LAT_W-1:0] r_cnt;
   logic [LAT_W-1:0] w_dec;
   logic [LAT_W-1:0] w_next;

   function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
      return (v == '0) ? '0 : v - LAT_W'(1);
   endfunction

   function automatic logic [LAT_W-1:0] lat_max(input logic [LAT_W-1:0] a,
                                                input logic [LAT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign w_dec  = sat_dec(r_cnt);
   // Keeping the max protects against a fast writer overtaking a slower one (WAW)
   assign w_next = i_load ? lat_max(w_dec, i_lat) : w_dec;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_cnt <= '0;
      else       r_cnt <= w_next;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/stall_scoreboard.sv
// Decode-stage stall unit built on a per-register latency scoreboard.
// Optional stall-cycle counter enabled by defining STALL_SCOREBOARD_PERF_EN.
module stall_scoreboard
   import stall_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int LAT_W      = LAT_W_DEF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [REG_ADDR_W-1:0] DE_SRC1,
   input  logic [REG_ADDR_W-1:0] DE_SRC2,
   input  logic                  DE_SRC1_USED,
   input  logic                  DE_SRC2_USED,
   input  logic                  DE_VALID,
   input  logic                  DE_WE,
   input  logic [REG_ADDR_W-1:0] DE_RD,
   input  logic [LAT_W-1:0]      DE_LAT,
   input  logic                  FLUSH,
   output logic                  STALL_PROCESSOR,
   output logic [1:0]            TYPE,
   output logic                  BUSY,
   output logic [31:0]           STALL_COUNT
);

   logic [LAT_W-1:0] w_cnt [NUM_REGS];
   logic             w_h1;
   logic             w_h2;
   logic             w_stall;
   logic             w_issue;
   logic             w_busy;

   assign w_cnt[0] = '0;

   // Hazards use pre-update counts, so an instruction never stalls on its own rd
   assign w_h1 = DE_VALID & DE_SRC1_USED & (DE_SRC1 != '0) & (w_cnt[DE_SRC1] != '0);
   assign w_h2 = DE_VALID & DE_SRC2_USED & (DE_SRC2 != '0) & (w_cnt[DE_SRC2] != '0);
   assign w_stall = w_h1 | w_h2;

   assign w_issue = DE_VALID & DE_WE & (DE_RD != '0) & ~w_stall & ~FLUSH;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      logic w_load;
      assign w_load = w_issue & (DE_RD == REG_ADDR_W'(r));
      reg_lat_counter #(
         .LAT_W (LAT_W)
      ) u_cnt (
         .i_clk  (CLK),
         .i_rst  (RESET),
         .i_load (w_load),
         .i_lat  (DE_LAT),
         .o_cnt  (w_cnt[r])
      );
   end

   always_comb begin
      w_busy = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (w_cnt[r] != '0) w_busy = 1'b1;
      end
   end

   assign STALL_PROCESSOR = w_stall;
   assign TYPE            = {w_h2, w_h1};
   assign BUSY            = w_busy;

`ifdef STALL_SCOREBOARD_PERF_EN
   logic [31:0] r_stall_count;

   always_ff @(posedge CLK) begin
      if (RESET)
         r_stall_count <= '0;
      else if (w_stall && (r_stall_count != 32'hFFFF_FFFF))
         r_stall_count <= r_stall_count + 32'd1;
   end

   assign STALL_COUNT = r_stall_count;
`else
   assign STALL_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_stall_scoreboard.sv
// Self-checking bench for stall_scoreboard: a ready-time model checked every
// cycle plus directed scenarios with literal expectations.
module tb_stall_scoreboard;
   import stall_pkg::*;

   logic        CLK;
   logic        RESET;
   logic [4:0]  DE_SRC1, DE_SRC2, DE_RD;
   logic        DE_SRC1_USED, DE_SRC2_USED, DE_VALID, DE_WE, FLUSH;
   logic [2:0]  DE_LAT;
   logic        STALL_PROCESSOR;
   logic [1:0]  TYPE;
   logic        BUSY;
   logic [31:0] STALL_COUNT;

   int nchk = 0;
   int nerr = 0;
   bit en   = 0;

   // Model: cycle at which each register's value becomes forwardable
   int          rdy [32];
   int          mcyc = 0;
   int unsigned pcnt = 0;

   stall_scoreboard dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .DE_SRC1         (DE_SRC1),
      .DE_SRC2         (DE_SRC2),
      .DE_SRC1_USED    (DE_SRC1_USED),
      .DE_SRC2_USED    (DE_SRC2_USED),
      .DE_VALID        (DE_VALID),
      .DE_WE           (DE_WE),
      .DE_RD           (DE_RD),
      .DE_LAT          (DE_LAT),
      .FLUSH           (FLUSH),
      .STALL_PROCESSOR (STALL_PROCESSOR),
      .TYPE            (TYPE),
      .BUSY            (BUSY),
      .STALL_COUNT     (STALL_COUNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      bit e1, e2, es, eb, iss;
      int t;
      e1 = DE_VALID && DE_SRC1_USED && (DE_SRC1 != 0) && (rdy[DE_SRC1] > mcyc);
      e2 = DE_VALID && DE_SRC2_USED && (DE_SRC2 != 0) && (rdy[DE_SRC2] > mcyc);
      es = e1 || e2;
      eb = 0;
      for (int r = 1; r < 32; r++) if (rdy[r] > mcyc) eb = 1;
      if (en) begin
         chk("model_stall", 32'(STALL_PROCESSOR), 32'(es));
         chk("model_type", 32'(TYPE), {30'd0, e2, e1});
         chk("model_busy", 32'(BUSY), 32'(eb));
`ifdef STALL_SCOREBOARD_PERF_EN
         chk("model_perf", STALL_COUNT, pcnt);
`else
         chk("model_perf", STALL_COUNT, 32'd0);
`endif
      end
      iss = DE_VALID && DE_WE && (DE_RD != 0) && !es && !FLUSH;
      if (RESET) begin
         for (int r = 0; r < 32; r++) rdy[r] = mcyc + 1;
         pcnt = 0;
      end else begin
         if (iss) begin
            t = mcyc + 1 + int'(DE_LAT);
            if (t > rdy[DE_RD]) rdy[DE_RD] = t;
         end
         if (es && pcnt != 32'hFFFF_FFFF) pcnt++;
      end
      mcyc++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_de(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                         input bit we, input int rd, input int lat, input bit fl);
      DE_VALID = v; DE_SRC1 = 5'(s1); DE_SRC1_USED = u1; DE_SRC2 = 5'(s2);
      DE_SRC2_USED = u2; DE_WE = we; DE_RD = 5'(rd); DE_LAT = 3'(lat); FLUSH = fl;
   endtask

   task automatic idle();
      set_de(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic load_use();
      set_de(1, 0, 0, 0, 0, 1, 5, LAT_LOAD, 0);      // lw x5
      #2 chk("lu_issue_nostall", 32'(STALL_PROCESSOR), 0);
      tick();
      set_de(1, 5, 1, 1, 1, 1, 6, LAT_ALU, 0);       // add x6,x5,x1
      #2 chk("lu_stall", 32'(STALL_PROCESSOR), 1);
      chk("lu_type", 32'(TYPE), 32'(STALL_RS1));
      tick();
      #2 chk("lu_proceed", 32'(STALL_PROCESSOR), 0);
      tick();
      idle();
   endtask

   task automatic mul_chain();
      set_de(1, 0, 0, 0, 0, 1, 7, LAT_MUL, 0);       // mul x7
      tick();
      set_de(1, 2, 1, 7, 1, 0, 0, 0, 0);             // reader of x7 as rs2
      for (int i = 0; i < 3; i++) begin
         #2 chk("mul_stall", 32'(STALL_PROCESSOR), 1);
         chk("mul_type", 32'(TYPE), 32'(STALL_RS2));
         if (i == 2) chk("mul_busy_last", 32'(BUSY), 1);
         tick();
      end
      #2 chk("mul_proceed", 32'(STALL_PROCESSOR), 0);
      chk("mul_busy_fall", 32'(BUSY), 0);
      tick();
      idle();
   endtask

   initial begin
      int n;
      for (int r = 0; r < 32; r++) rdy[r] = 0;
      RESET = 1'b1;
      idle();
      tick();
      tick();
      RESET = 1'b0;
      en = 1;
      #2 chk("reset_stall", 32'(STALL_PROCESSOR), 0);
      chk("reset_busy", 32'(BUSY), 0);
      chk("reset_perf", STALL_COUNT, 0);
      tick();

      load_use();
      tick();
      mul_chain();
      tick();

      // Both sources on the same pending register
      set_de(1, 0, 0, 0, 0, 1, 3, LAT_MUL, 0);
      tick();
      set_de(1, 3, 1, 3, 1, 1, 4, LAT_ALU, 0);
      #2 chk("both_type", 32'(TYPE), 32'(STALL_BOTH));
      tick(); tick(); tick();
      #2 chk("both_proceed", 32'(STALL_PROCESSOR), 0);
      tick();
      // Writes to x0 are never tracked
      set_de(1, 0, 0, 0, 0, 1, 0, 7, 0);
      tick();
      set_de(1, 0, 1, 0, 1, 0, 0, 0, 0);
      #2 chk("x0_stall", 32'(STALL_PROCESSOR), 0);
      chk("x0_busy", 32'(BUSY), 0);
      tick();

      // WAW: fast writer must not shorten the slow writer's countdown
      set_de(1, 0, 0, 0, 0, 1, 9, 5, 0);
      tick();
      set_de(1, 0, 0, 0, 0, 1, 9, 0, 0);
      tick();
      set_de(1, 9, 1, 0, 0, 0, 0, 0, 0);
      n = 0;
      #2;
      while (STALL_PROCESSOR && n < 10) begin
         n++;
         tick();
         #2;
      end
      chk("waw_stall_cycles", 32'(n), 4);
      tick();

      // FLUSH suppresses issue but not the stall output
      set_de(1, 0, 0, 0, 0, 1, 10, 3, 1);
      #2 chk("flush_nostall", 32'(STALL_PROCESSOR), 0);
      tick();
      set_de(1, 10, 1, 0, 0, 0, 0, 0, 0);
      #2 chk("flush_no_counter", 32'(STALL_PROCESSOR), 0);
      chk("flush_busy", 32'(BUSY), 0);
      tick();
      set_de(1, 0, 0, 0, 0, 1, 11, 2, 0);
      tick();
      set_de(1, 11, 1, 0, 0, 0, 0, 0, 1);
      #2 chk("flush_keeps_stall", 32'(STALL_PROCESSOR), 1);
      tick();
      idle();
      tick(); tick();

      // Reset while x5 still has two cycles to go
      set_de(1, 0, 0, 0, 0, 1, 5, 2, 0);
      tick();
      idle();
      RESET = 1'b1;
      #2 chk("pre_reset_busy", 32'(BUSY), 1);
      tick();
      RESET = 1'b0;
      set_de(1, 5, 1, 0, 0, 0, 0, 0, 0);
      #2 chk("post_reset_stall", 32'(STALL_PROCESSOR), 0);
      chk("post_reset_busy", 32'(BUSY), 0);
      chk("post_reset_type", 32'(TYPE), 0);
      tick();
      idle();

      // Counter after reset: 1 load-use stall + 3 MUL stalls
      load_use();
      mul_chain();
      #2;
`ifdef STALL_SCOREBOARD_PERF_EN
      chk("perf_count", STALL_COUNT, 4);
`else
      chk("perf_count", STALL_COUNT, 0);
`endif
      tick();
      en = 0;
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stall_scoreboard.md
Name: stall_scoreboard

Overview:
- Parametrised successor to the decode-stage stall unit of the RISC-V pipeline.
- Replaces fixed EM/MW RD comparison with a per-register latency scoreboard: each issued writer loads a countdown of cycles until its result is forwardable.
- Decode stalls while any used source register has a nonzero countdown.
- Supports variable-latency units (load, MUL/DIV) and a drain indication for fences.

Parameters:
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
- REG_ADDR_W, 5, register address width; must equal clog2(NUM_REGS).
- LAT_W, 3, countdown width; maximum latency is 2^LAT_W-1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DE_SRC1  in  REG_ADDR_W  rs1 of instruction in decode.
- DE_SRC2  in  REG_ADDR_W  rs2 of instruction in decode.
- DE_SRC1_USED  in  1  rs1 is a real operand.
- DE_SRC2_USED  in  1  rs2 is a real operand.
- DE_VALID  in  1  decode holds a valid instruction.
- DE_WE  in  1  decode instruction writes a register.
- DE_RD  in  REG_ADDR_W  destination of decode instruction.
- DE_LAT  in  LAT_W  extra cycles before the result is forwardable; 0 means forwardable next cycle.
- FLUSH  in  1  kill decode instruction this cycle (branch redirect).
- STALL_PROCESSOR  out  1  hold PC/IF/DE, insert bubble into EX.
- TYPE  out  2  stall cause: 00 none, 01 rs1, 10 rs2, 11 both.
- BUSY  out  1  any counter nonzero.
- STALL_COUNT  out  32  stall-cycle counter (see optional feature).

Behaviour:
- State: cnt[r], LAT_W bits, r = 1..NUM_REGS-1. cnt[0] is constant 0.
- Hazard terms (combinational, using current cnt):
  - h1 = DE_VALID & DE_SRC1_USED & (DE_SRC1!=0) & (cnt[DE_SRC1]!=0); h2 is the same for rs2.
  - TYPE = {h2,h1}; STALL_PROCESSOR = h1|h2.
  - Outputs are combinational from registered state; no extra latency.
- Issue: issue = DE_VALID & DE_WE & (DE_RD!=0) & !STALL_PROCESSOR & !FLUSH.
- Per-register update each edge, highest priority first:
  - RESET: cnt <= 0.
  - Issue to r: cnt[r] <= max(dec(cnt[r]), DE_LAT). The max covers WAW against a slower in-flight writer.
  - Otherwise: cnt[r] <= dec(cnt[r]), where dec saturates at 0.
- Self-dependency (DE_SRC == DE_RD): the check uses pre-update cnt, so the instruction does not stall on itself.
- Timing: writer issues at cycle t with DE_LAT=k, dependent enters decode at t+1.
  - Dependent stalls cycles t+1..t+k and proceeds at t+k+1.
  - k=0 gives no stall (full forwarding assumed).
- FLUSH: suppresses issue only. Existing counters keep decrementing, because older in-flight writers still complete. FLUSH does not force STALL_PROCESSOR low.
- RESET mid-operation: all counters 0 the next cycle. STALL_PROCESSOR, TYPE and BUSY are 0 after the reset edge.
- BUSY = OR of all cnt != 0; reset value 0.

Optional Feature:
- Macro STALL_SCOREBOARD_PERF_EN.
- Defined: STALL_COUNT increments on every cycle with STALL_PROCESSOR=1, saturates at 32'hFFFFFFFF, and clears on RESET.
- Undefined: no counter logic; STALL_COUNT is tied to 0.

Decomposition:
- Shared package stall_pkg holds:
  - REG_ADDR_W and LAT_W defaults;
  - TYPE encodings STALL_NONE/STALL_RS1/STALL_RS2/STALL_BOTH;
  - latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3.
- One sub-module, reg_lat_counter: a single saturating countdown with load-max, instantiated NUM_REGS-1 times via generate.

Test Plan:
- Load-use: lw x5 (DE_LAT=1) at t, then add x6,x5,x1 at t+1 -> STALL_PROCESSOR=1, TYPE=01 at t+1 only; proceeds at t+2.
- MUL chain: mul x7 (DE_LAT=3), then use of x7 as rs2 -> STALL=1, TYPE=10 for exactly 3 cycles; BUSY falls after the last.
- Both sources: mul x3 (DE_LAT=3) then add x4,x3,x3 -> TYPE=11. Also x0 source with DE_LAT=7 writer to x0 -> never stalls, BUSY stays 0.
- WAW: mul x9 (LAT=5), then addi x9 (LAT=0) next cycle -> cnt[9] stays 4, not 0; a reader stalls 4 cycles.
- FLUSH and reset: issue with FLUSH=1 sets no counter. RESET asserted while cnt[5]=2 -> next cycle STALL=0 and BUSY=0.
- Perf (macro defined): 3+1 stall cycles as above -> STALL_COUNT=4. With macro undefined -> STALL_COUNT=0.
